// File: rtl/mc_datapath_regs.sv
// Register state of the multicycle MIPS datapath: PC, IR, MDR, register file,
// A/B operand latches and ALUOut, plus the fields decoded from IR.
module mc_datapath_regs #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IorD,
    input  logic             IRWrite,
    input  logic             PCWrite,
    input  logic             Branch,
    input  logic             PCSrc,
    input  logic             RegWrite,
    input  logic             RegDst,
    input  logic             MemtoReg,
    input  logic             Zero,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [WIDTH-1:0] MemRdata,
    output logic [WIDTH-1:0] MemAddr,
    output logic [WIDTH-1:0] MemWdata,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUOut,
    output logic [WIDTH-1:0] SignImm,
    output logic [5:0]       Opcode,
    output logic [5:0]       Funct
);

    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] mdr;
    logic [WIDTH-1:0] rf [32];

    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       wraddr;
    logic [WIDTH-1:0] wrdata;
    logic             pcen;

    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign wraddr = RegDst ? rd : rt;
    assign wrdata = MemtoReg ? mdr : ALUOut;
    assign pcen   = PCWrite | (Branch & Zero);

    assign MemAddr  = IorD ? ALUOut : PC;
    assign MemWdata = B;
    assign Opcode   = ir[31:26];
    assign Funct    = ir[5:0];
    assign SignImm  = {{(WIDTH-16){ir[15]}}, ir[15:0]};

    // A/B sample the register file before this edge's write lands, so there is
    // no write-to-read bypass; register 0 is never written and so reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            PC     <= RESET_PC;
            ir     <= '0;
            mdr    <= '0;
            A      <= '0;
            B      <= '0;
            ALUOut <= '0;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (pcen) begin
                PC <= PCSrc ? ALUOut : ALUResult;
            end
            if (IRWrite) begin
                ir <= MemRdata;
            end
            mdr    <= MemRdata;
            ALUOut <= ALUResult;
            A      <= rf[rs];
            B      <= rf[rt];
            if (RegWrite && (wraddr != 5'd0)) begin
                rf[wraddr] <= wrdata;
            end
        end
    end

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Self-checking bench for mc_datapath_regs: directed scenarios followed by
// randomized cycles, all compared against a behavioural model of the datapath.
module tb_mc_datapath_regs;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, IorD, IRWrite, PCWrite, Branch, PCSrc;
    logic        RegWrite, RegDst, MemtoReg, Zero;
    logic [31:0] ALUResult, MemRdata;
    logic [31:0] MemAddr, MemWdata, PC, A, B, ALUOut, SignImm;
    logic [5:0]  Opcode, Funct;

    int nChecks = 0;
    int nBad    = 0;

    // behavioural model of the architectural state
    logic [31:0] mPc, mIr, mMdr, mA, mB, mAluOut;
    logic [31:0] mRf [32];
    bit          modelValid = 0;

    mc_datapath_regs #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .Branch(Branch), .PCSrc(PCSrc), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .Zero(Zero), .ALUResult(ALUResult), .MemRdata(MemRdata),
        .MemAddr(MemAddr), .MemWdata(MemWdata), .PC(PC), .A(A), .B(B),
        .ALUOut(ALUOut), .SignImm(SignImm), .Opcode(Opcode), .Funct(Funct)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clearInputs();
        rst = 0; IorD = 0; IRWrite = 0; PCWrite = 0; Branch = 0; PCSrc = 0;
        RegWrite = 0; RegDst = 0; MemtoReg = 0; Zero = 0;
        ALUResult = '0; MemRdata = '0;
    endtask

    task automatic checkAll();
        checkOutput("PC",       PC,       mPc);
        checkOutput("A",        A,        mA);
        checkOutput("B",        B,        mB);
        checkOutput("ALUOut",   ALUOut,   mAluOut);
        checkOutput("MemAddr",  MemAddr,  IorD ? mAluOut : mPc);
        checkOutput("MemWdata", MemWdata, mB);
        checkOutput("Opcode",   {26'd0, Opcode}, {26'd0, mIr[31:26]});
        checkOutput("Funct",    {26'd0, Funct},  {26'd0, mIr[5:0]});
        checkOutput("SignImm",  SignImm,  32'($signed(mIr[15:0])));
    endtask

    // Advance the model by one clock edge with the currently driven inputs.
    task automatic stepModel();
        logic [31:0] nA, nB;
        int          dst;
        if (rst) begin
            mPc = RESET_PC; mIr = 0; mMdr = 0; mA = 0; mB = 0; mAluOut = 0;
            for (int i = 0; i < 32; i++) mRf[i] = 0;
            modelValid = 1;
            return;
        end
        nA  = mRf[mIr[25:21]];
        nB  = mRf[mIr[20:16]];
        dst = RegDst ? int'(mIr[15:11]) : int'(mIr[20:16]);
        if (RegWrite && dst != 0) mRf[dst] = MemtoReg ? mMdr : mAluOut;
        if (PCWrite || (Branch && Zero)) mPc = PCSrc ? mAluOut : ALUResult;
        if (IRWrite) mIr = MemRdata;
        mMdr    = MemRdata;
        mAluOut = ALUResult;
        mA      = nA;
        mB      = nB;
    endtask

    // Inputs are already set by the caller; hold them across one rising edge.
    task automatic applyStimulus();
        @(negedge clk);
        #1;
        if (modelValid) checkAll();
        @(posedge clk);
        stepModel();
        #1;
    endtask

    initial begin
        clearInputs();

        // reset wins over every enable
        rst = 1; IorD = 1; IRWrite = 1; PCWrite = 1; Branch = 1; Zero = 1;
        RegWrite = 1; ALUResult = 32'h1234; MemRdata = 32'hFFFF_FFFF;
        applyStimulus();
        checkOutput("rst_PC", PC, RESET_PC);
        checkOutput("rst_A", A, 32'h0);
        checkOutput("rst_B", B, 32'h0);
        checkOutput("rst_ALUOut", ALUOut, 32'h0);
        checkOutput("rst_MemAddr", MemAddr, RESET_PC);
        checkOutput("rst_Opcode", {26'd0, Opcode}, 32'h0);

        // fetch
        clearInputs();
        IRWrite = 1; PCWrite = 1; MemRdata = 32'h012A_4020; ALUResult = 32'd4;
        applyStimulus();
        checkOutput("fetch_Opcode", {26'd0, Opcode}, 32'h0);
        checkOutput("fetch_Funct", {26'd0, Funct}, 32'h20);
        checkOutput("fetch_PC", PC, 32'd4);

        // R-type: ALUOut=0x15 then write rd=8
        clearInputs(); ALUResult = 32'h15; applyStimulus();
        clearInputs(); RegWrite = 1; RegDst = 1; applyStimulus();
        checkOutput("rtype_A_old", A, 32'h0);
        clearInputs(); IRWrite = 1; MemRdata = 32'h0109_0000; ALUResult = 32'h40;
        applyStimulus();
        IorD = 1; #1;
        checkOutput("load_MemAddr", MemAddr, 32'h40);
        clearInputs(); IorD = 1; MemRdata = 32'hDEAD_BEEF; applyStimulus();
        checkOutput("rtype_A_new", A, 32'h15);
        clearInputs(); RegWrite = 1; MemtoReg = 1; applyStimulus();
        checkOutput("load_B_nobypass", B, 32'h0);
        clearInputs(); applyStimulus();
        checkOutput("load_B", B, 32'hDEAD_BEEF);
        checkOutput("load_MemWdata", MemWdata, 32'hDEAD_BEEF);

        // branch not taken then taken
        clearInputs(); ALUResult = 32'h100; applyStimulus();
        clearInputs(); Branch = 1; PCSrc = 1; ALUResult = 32'h100; applyStimulus();
        checkOutput("br_nottaken_PC", PC, 32'd4);
        clearInputs(); Branch = 1; PCSrc = 1; Zero = 1; ALUResult = 32'h100; applyStimulus();
        checkOutput("br_taken_PC", PC, 32'h100);

        // write to $zero is discarded
        clearInputs(); IRWrite = 1; MemRdata = 32'h0000_0020; applyStimulus();
        clearInputs(); ALUResult = 32'h55; applyStimulus();
        clearInputs(); RegWrite = 1; RegDst = 1; applyStimulus();
        clearInputs(); applyStimulus();
        checkOutput("zero_A", A, 32'h0);
        checkOutput("zero_B", B, 32'h0);

        // sign extension
        clearInputs(); IRWrite = 1; MemRdata = 32'h0000_8004; applyStimulus();
        checkOutput("simm_neg", SignImm, 32'hFFFF_8004);
        clearInputs(); IRWrite = 1; MemRdata = 32'h0000_7FFF; applyStimulus();
        checkOutput("simm_pos", SignImm, 32'h0000_7FFF);

        // reset on the same edge as a PC write
        clearInputs(); rst = 1; PCWrite = 1; ALUResult = 32'h123; applyStimulus();
        checkOutput("rst_pcwrite_PC", PC, RESET_PC);
        checkOutput("rst_SignImm", SignImm, 32'h0);

        // randomized cycles against the model
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 39) == 0);
            IorD      = 1'($urandom);
            IRWrite   = ($urandom_range(0, 3) == 0);
            PCWrite   = ($urandom_range(0, 3) == 0);
            Branch    = 1'($urandom);
            PCSrc     = 1'($urandom);
            RegWrite  = 1'($urandom);
            RegDst    = 1'($urandom);
            MemtoReg  = 1'($urandom);
            Zero      = 1'($urandom);
            ALUResult = $urandom;
            MemRdata  = $urandom;
            applyStimulus();
        end
        clearInputs();
        applyStimulus();

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule

// File: doc/mc_datapath_regs.md
# mc_datapath_regs

Architectural and non-architectural state of the multicycle MIPS datapath, driven directly by the control unit's strobes. Holds PC, instruction register (IR), memory data register (MDR), the 32×32 register file, operand latches A/B and ALUOut, and produces the memory address, the Opcode/Funct fields fed back to the control unit, and the sign-extended immediate. Sits between unified instruction/data memory, the ALU, and the control unit, one step downstream of the control unit.

## Interface
- WIDTH, 32: datapath width in bits.
- RESET_PC, 32'h0000_0000: PC value after reset.

- clk  in  1  rising-edge clock, single domain.
- rst  in  1  synchronous, active-high reset.
- IorD  in  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  in  1  load IR from MemRdata.
- PCWrite  in  1  unconditional PC update.
- Branch  in  1  conditional PC update when Zero=1.
- PCSrc  in  1  PC next source: 0 = ALUResult, 1 = ALUOut.
- RegWrite  in  1  register-file write enable.
- RegDst  in  1  write address: 0 = IR[20:16], 1 = IR[15:11].
- MemtoReg  in  1  write data: 0 = ALUOut, 1 = MDR.
- Zero  in  1  ALU zero flag (current cycle).
- ALUResult  in  WIDTH  ALU result (current cycle).
- MemRdata  in  WIDTH  memory read data, valid same cycle as MemAddr.
- MemAddr  out  WIDTH  memory address (combinational).
- MemWdata  out  WIDTH  store data = B.
- PC  out  WIDTH  program counter.
- A, B  out  WIDTH  operand latches.
- ALUOut  out  WIDTH  registered ALU result.
- SignImm  out  WIDTH  sign-extended IR[15:0].
- Opcode  out  6  IR[31:26].
- Funct  out  6  IR[5:0].

## Operation
- Reset (rst=1 at rising edge), priority over every enable: PC←RESET_PC; IR, MDR, A, B, ALUOut←0; all 32 registers←0. Hence Opcode=0, Funct=0, SignImm=0, MemAddr=RESET_PC.
- PC: PCEn = PCWrite | (Branch & Zero). When PCEn, PC←(PCSrc ? ALUOut : ALUResult); else hold.
- MemAddr = IorD ? ALUOut : PC. MemWdata = B.
- IR: loads MemRdata when IRWrite; else holds. All IR-derived outputs (Opcode, Funct, rs, rt, rd, SignImm) come from the registered IR.
- MDR, ALUOut: load MemRdata and ALUResult, respectively, every non-reset cycle (no enable).
- Register file: asynchronous read of rs=IR[25:21], rt=IR[20:16]; A←rf[rs], B←rf[rt] every non-reset cycle.
- Write: on RegWrite, rf[RegDst ? IR[15:11] : IR[20:16]] ← (MemtoReg ? MDR : ALUOut). Writes to register 0 are discarded; rf[0] reads 0 always.
- No write-to-read bypass: same-edge write and A/B capture, A/B get the pre-write value.
- Same-edge IRWrite and RegWrite: write address uses the old IR.
- SignImm = {{(WIDTH-16){IR[15]}}, IR[15:0]}.

## Timing
- All state updates on the rising clk edge; rst sampled synchronously.
- MemAddr, MemWdata, Opcode, Funct, SignImm: combinational from registers, no extra latency.
- Memory read: address presented in cycle N, MemRdata captured into IR/MDR at end of N, visible N+1.
- ALUResult in cycle N → ALUOut in N+1; register written at end of N → readable in A/B at end of N+1.
- Branch: Zero and Branch sampled in the same cycle; PCSrc selects ALUOut (branch target computed previously).
- Reset mid-instruction: all state reset at that edge, in-flight write/PC update discarded; fetch restarts at RESET_PC the next cycle.

## Test plan
- Reset: drive enables high with rst=1 → after edge, PC=RESET_PC, IR=0, A=B=ALUOut=0, MemAddr=RESET_PC, rf[1..31]=0.
- Fetch: IorD=0, IRWrite=1, PCWrite=1, PCSrc=0, MemRdata=32'h012A4020, ALUResult=4 → IR=32'h012A4020, Opcode=0, Funct=6'h20, PC=4.
- R-type write: IR=32'h012A4020, ALUResult=32'h15 then RegWrite=1, RegDst=1, MemtoReg=0 → rf[8]=32'h15; next cycle with rs=8, A=32'h15; same-edge capture gave old value.
- Load path: IorD=1, ALUOut=32'h40 → MemAddr=32'h40; MemRdata=32'hDEAD_BEEF → MDR; MemtoReg=1, RegDst=0, rt=9 → rf[9]=32'hDEAD_BEEF.
- Branch: Branch=1, PCSrc=1, ALUOut=32'h100, Zero=0 → PC unchanged; Zero=1 → PC=32'h100. $zero write with rd=0 → rf[0] stays 0.
- SignImm: IR[15:0]=16'h8004 → SignImm=32'hFFFF_8004; 16'h7FFF → 32'h0000_7FFF. Reset asserted same edge as PCWrite=1 → PC=RESET_PC.
